// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit -- instruction fetch stage of the single-issue RV32I core.
//
// Holds the program counter, fetches one 32-bit word at a time over a
// request/acknowledge instruction-memory port and hands {inst, pc, pc_4}
// with a valid flag to decode. Redirects from execute (taken branch, jal,
// jalr) restart fetch at a new address; a fetch already in flight when a
// redirect arrives is allowed to complete and its data is thrown away.
//
// Ports
//   clk, rst          core clock; asynchronous active-high reset
//   imem_req          fetch request (high in REQ and DROP)
//   imem_addr         registered fetch address, stable while imem_req is high
//   imem_ack          completion; imem_rdata is valid in the same cycle
//   imem_rdata        fetched instruction word
//   stall             decode cannot accept; hold the current instruction
//   redirect          one-cycle PC-change request from execute
//   redirect_target   new PC, sampled with redirect
//   inst, pc, pc_4    instruction to decode, its address, address + 4
//   inst_valid        inst/pc/pc_4 are valid for decode
//   fault             sticky misaligned-redirect fault; only rst clears it
//   fsm_state         current fetch FSM state, for observation only
//
// Memory handshake: a request is raised with imem_addr and held, address
// unchanged, until the cycle imem_ack is high; that cycle completes it and
// imem_rdata is taken from that same cycle. A request is never withdrawn,
// and at most one is outstanding.
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        inst_valid,
  output logic        fault,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_VALID = 3'd2,
    S_DROP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] pending_q;   // latest redirect target seen while in DROP
  logic        req_q;
  logic        valid_q;
  logic        fault_q;

  // A redirect is only acted on while fetch is live (REQ, DROP, VALID).
  logic accepting;
  logic bad_redirect;

  always_comb begin
    accepting    = (state_q == S_REQ) || (state_q == S_DROP) ||
                   (state_q == S_VALID);
    bad_redirect = accepting && redirect && (redirect_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_PC;
      inst_q    <= 32'd0;
      pc_q      <= RESET_PC;
      pending_q <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else if (bad_redirect) begin
      // Misaligned target: park in FAULT with the offending address in pc.
      // Any outstanding request is abandoned; only reset leaves FAULT.
      state_q <= S_FAULT;
      pc_q    <= redirect_target;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Ack is ignored here, which also discards a completion belonging
          // to a request cut off by reset.
          state_q <= S_REQ;
          addr_q  <= RESET_PC;
          req_q   <= 1'b1;
        end

        S_REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              // Old request completes this cycle: drop its data and
              // immediately request the new target.
              addr_q <= redirect_target;
            end else begin
              // Cannot withdraw the request; remember where to go next.
              pending_q <= redirect_target;
              state_q   <= S_DROP;
            end
          end else if (imem_ack) begin
            inst_q  <= imem_rdata;
            pc_q    <= addr_q;
            state_q <= S_VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end

        S_DROP: begin
          if (imem_ack) begin
            // Data is discarded. A redirect in the ack cycle is the latest
            // one, so it takes precedence over the stored target.
            addr_q  <= redirect ? redirect_target : pending_q;
            state_q <= S_REQ;
          end else if (redirect) begin
            pending_q <= redirect_target;
          end
        end

        S_VALID: begin
          if (redirect) begin
            addr_q  <= redirect_target;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (!stall) begin
            addr_q  <= pc_q + 32'd4;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end

        S_FAULT: begin
          state_q <= S_FAULT;
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    imem_req   = req_q;
    imem_addr  = addr_q;
    inst       = inst_q;
    pc         = pc_q;
    pc_4       = pc_q + 32'd4;   // carry out discarded: 0xFFFFFFFC -> 0
    inst_valid = valid_q;
    fault      = fault_q;
    fsm_state  = state_q;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit -- self-checking bench for ifetch_unit.
//   1. table of per-cycle vectors: sequential fetch, stall hold, redirect
//      under stall
//   2. hand-written sequences: redirects during a memory wait, misaligned
//      target / fault, address wrap, reset mid-fetch
//   3. randomized traffic checked against an instruction-stream model
// Memory content is addr ^ 32'hA5A5_A5A5 everywhere.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        inst_valid;
  logic        fault;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .inst            (inst),
    .pc              (pc),
    .pc_4            (pc_4),
    .inst_valid      (inst_valid),
    .fault           (fault),
    .fsm_state       (fsm_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Apply inputs for one cycle, clock it, and return #1 after the edge with
  // the registered outputs settled.
  task automatic drive(input logic s, input logic r, input logic [31:0] t,
                       input logic a);
    stall           = s;
    redirect        = r;
    redirect_target = t;
    imem_ack        = a;
    imem_rdata      = a ? mem_word(imem_addr) : $urandom;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_req"},   imem_req,   1'b0);
    chk1({tag, "_valid"}, inst_valid, 1'b0);
    chk1({tag, "_fault"}, fault,      1'b0);
    chk ({tag, "_addr"},  imem_addr,  RESET_PC);
    chk ({tag, "_pc"},    pc,         RESET_PC);
    chk ({tag, "_pc4"},   pc_4,       RESET_PC + 32'd4);
    chk ({tag, "_inst"},  inst,       32'd0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        ack;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic s, input logic r, input logic [31:0] t,
                         input logic a, input logic er, input logic ev,
                         input logic [31:0] ea, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.target = t; v.ack = a;
    v.exp_req = er; v.exp_valid = ev; v.exp_addr = ea; v.exp_pc = ep;
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [31:0] a;
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    logic        s, r, ak;
    logic [31:0] t;
    int          delivered;

    // Build the vector table: zero-wait sequential fetch up to 0x00400020,
    // a 5-cycle stall there, resume, then redirect-under-stall.
    add_vec(0, 0, 0, 0, 1, 0, RESET_PC, RESET_PC);           // IDLE -> REQ
    for (int k = 0; k <= 8; k++) begin
      a = RESET_PC + 32'(4 * k);
      add_vec(0, 0, 0, 1, 0, 1, a, a);                       // ack -> VALID
      if (k < 8) add_vec(0, 0, 0, 0, 1, 0, a + 32'd4, a);    // next REQ
    end
    for (int k = 0; k < 5; k++)
      add_vec(1, 0, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0020);
    add_vec(0, 0, 0, 0, 1, 0, 32'h0040_0024, 32'h0040_0020);
    add_vec(0, 0, 0, 1, 0, 1, 32'h0040_0024, 32'h0040_0024);
    add_vec(1, 1, 32'h0040_001C, 0, 1, 0, 32'h0040_001C, 32'h0040_0024);
    add_vec(0, 0, 0, 1, 0, 1, 32'h0040_001C, 32'h0040_001C);

    do_reset();
    check_reset("reset");

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].target, tbl[i].ack);
      chk1($sformatf("vec%0d_req", i),   imem_req,   tbl[i].exp_req);
      chk1($sformatf("vec%0d_valid", i), inst_valid, tbl[i].exp_valid);
      chk ($sformatf("vec%0d_addr", i),  imem_addr,  tbl[i].exp_addr);
      chk ($sformatf("vec%0d_pc", i),    pc,         tbl[i].exp_pc);
      chk ($sformatf("vec%0d_pc4", i),   pc_4,       tbl[i].exp_pc + 32'd4);
      if (tbl[i].exp_valid)
        chk($sformatf("vec%0d_inst", i), inst, mem_word(tbl[i].exp_pc));
    end

    // Redirects during a 3-cycle memory wait: the latest target wins and the
    // old data is never presented.
    drive(0, 0, 0, 0);
    chk ("wait_addr0", imem_addr, 32'h0040_0020);
    drive(0, 1, 32'h0040_0100, 0);
    chk1("wait1_req", imem_req, 1'b1);
    chk ("wait1_addr", imem_addr, 32'h0040_0020);
    chk1("wait1_valid", inst_valid, 1'b0);
    drive(0, 1, 32'h0040_0200, 0);
    chk ("wait2_addr", imem_addr, 32'h0040_0020);
    chk1("wait2_valid", inst_valid, 1'b0);
    drive(0, 0, 0, 1);
    chk1("oldack_valid", inst_valid, 1'b0);
    chk1("oldack_req", imem_req, 1'b1);
    chk ("oldack_addr", imem_addr, 32'h0040_0200);
    drive(0, 0, 0, 1);
    chk1("newdata_valid", inst_valid, 1'b1);
    chk ("newdata_pc", pc, 32'h0040_0200);
    chk ("newdata_inst", inst, mem_word(32'h0040_0200));

    // Misaligned target (redirect wins over stall) -> sticky fault.
    drive(1, 1, 32'h0040_0102, 0);
    chk1("fault_set", fault, 1'b1);
    chk ("fault_pc", pc, 32'h0040_0102);
    chk1("fault_req", imem_req, 1'b0);
    chk1("fault_valid", inst_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h0040_0300, 1);
      chk1($sformatf("fault_hold%0d", k), fault, 1'b1);
      chk1($sformatf("fault_hold%0d_req", k), imem_req, 1'b0);
      chk ($sformatf("fault_hold%0d_pc", k), pc, 32'h0040_0102);
    end
    do_reset();
    check_reset("fault_rst");
    drive(0, 0, 0, 0);
    chk1("restart_req", imem_req, 1'b1);
    chk ("restart_addr", imem_addr, RESET_PC);

    // Address wrap at the top of memory.
    drive(0, 0, 0, 1);
    chk1("pre_wrap_valid", inst_valid, 1'b1);
    drive(0, 1, 32'hFFFF_FFFC, 0);
    chk1("wrap_req", imem_req, 1'b1);
    chk ("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1);
    chk ("wrap_pc", pc, 32'hFFFF_FFFC);
    chk ("wrap_pc4", pc_4, 32'h0000_0000);
    drive(0, 0, 0, 0);
    chk1("wrap_next_req", imem_req, 1'b1);
    chk ("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Reset asserted mid-fetch clears immediately; the late ack is ignored.
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 1);           // stale ack arrives while in IDLE
    chk1("lateack_req", imem_req, 1'b1);
    chk1("lateack_valid", inst_valid, 1'b0);
    chk ("lateack_addr", imem_addr, RESET_PC);
    drive(0, 0, 0, 0);
    chk1("lateack_valid2", inst_valid, 1'b0);
    chk ("lateack_addr2", imem_addr, RESET_PC);

    // Randomized traffic. The model tracks only the address of the next
    // instruction decode should see: a redirect replaces it, an accepted
    // instruction advances it by 4.
    do_reset();
    exp_pc    = RESET_PC;
    delivered = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      chk1("rnd_fault", fault, 1'b0);
      chk1("rnd_exclusive", imem_req & inst_valid, 1'b0);
      if (inst_valid) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_inst", inst, mem_word(exp_pc));
        chk("rnd_pc4", pc_4, exp_pc + 32'd4);
        delivered++;
      end
      if (imem_req && prev_req && !prev_ack)
        chk("rnd_addr_stable", imem_addr, prev_addr);
      if (imem_req && (!prev_req || prev_ack))
        chk("rnd_new_req_addr", imem_addr, exp_pc);

      s  = ($urandom_range(0, 3) == 0);
      r  = (imem_req || inst_valid) && ($urandom_range(0, 9) == 0);
      t  = $urandom & 32'hFFFF_FFFC;
      ak = imem_req && ($urandom_range(0, 1) == 1);

      if (r) exp_pc = t;
      else if (inst_valid && !s) exp_pc = exp_pc + 32'd4;

      prev_req  = imem_req;
      prev_ack  = ak;
      prev_addr = imem_addr;
      drive(s, r, t, ak);
    end
    chk1("rnd_progress", delivered >= 200, 1'b1);

    // ---------------------------------------------------------------- report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
